button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 126 ++++++++++++
 tb/tb_button_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer feeding a 4-state debounce FSM.
// Define BUTTON_LONG_PRESS_EN to add the long-press counter and long_pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ICE_PB,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic LED_R
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync1 <= ICE_PB;
      sync  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      LED_R         <= 1'b1;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            LED_R       <= ~LED_R;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

  logic [23:0] long_cnt;
  logic        enter_held;
  logic        leave_held;
  logic        active;

  assign enter_held = (state == PRESS_WAIT) && sync && (cnt == CNT_LAST);
  assign leave_held = (state == RELEASE_WAIT) && !sync && (cnt == CNT_LAST);
  assign active     = (state == HELD) || (state == RELEASE_WAIT);

  // Saturates so a very long hold never re-fires long_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (enter_held) begin
        long_cnt <= '0;
      end else if (active && (long_cnt != '1)) begin
        long_cnt <= long_cnt + 1'b1;
      end
      if (active && !leave_held && (long_cnt == LONG_LAST)) begin
        long_pulse <= 1'b1;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized + directed bench for button_debounce with a queue scoreboard.
// A window-based reference model predicts every output each cycle.
module tb_button_debounce;

  localparam int D = 16;
  localparam int L = 64;

  logic clk;
  logic rst;
  logic ICE_PB;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic LED_R;

  int vectors;
  int miscompares;

  typedef struct {
    logic [4:0] v;
    longint     cyc;
  } exp_t;

  exp_t exp_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ICE_PB(ICE_PB),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .LED_R(LED_R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the last D+1 synchronized
  // samples all disagree with it; sync lags the pad by two edges.
  bit     pipe[$];
  bit     win[$];
  bit     lvl;
  bit     led;
  longint n;
  longint press_n;

  initial begin
    n       = 0;
    press_n = -1000000;
    lvl     = 1'b0;
    led     = 1'b1;
  end

  always @(posedge clk) begin
    bit   s;
    bit   flip;
    bit   pp;
    bit   rp;
    bit   lp;
    exp_t e;
    n++;
    pp = 1'b0;
    rp = 1'b0;
    lp = 1'b0;
    if (rst) begin
      pipe = {1'b0, 1'b0};
      win  = {};
      lvl  = 1'b0;
      led  = 1'b1;
      press_n = -1000000;
    end else begin
      pipe.push_back(ICE_PB);
      s = pipe.pop_front();
      win.push_back(s);
      if (win.size() > D + 1) void'(win.pop_front());
      flip = (win.size() == D + 1);
      foreach (win[i]) if (win[i] == lvl) flip = 1'b0;
      if (flip) begin
        lvl = !lvl;
        if (lvl) begin
          pp      = 1'b1;
          led     = !led;
          press_n = n;
        end else begin
          rp = 1'b1;
        end
      end
`ifdef BUTTON_LONG_PRESS_EN
      if (lvl && !pp && (n - press_n == L)) lp = 1'b1;
`endif
    end
    e.v   = {lvl, pp, rp, lp, led};
    e.cyc = n;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pressed, press_pulse, release_pulse, long_pulse, LED_R};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: {pressed,press,release,long,led} got %b want %b",
                 e.cyc, act, e.v);
      end
    end
  end

  task automatic drive(input bit r, input bit p, input int cycles);
    repeat (cycles) begin
      rst    = r;
      ICE_PB = p;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    ICE_PB      = 1'b0;

    drive(1, 0, 2);
    drive(0, 0, 5);
    // clean press then release
    drive(0, 1, 40);
    drive(0, 0, 30);
    // glitch, then a second clean press
    drive(0, 1, 10);
    drive(0, 0, 30);
    drive(0, 1, 40);
    drive(0, 0, 30);
    // long press
    drive(0, 1, 100);
    drive(0, 0, 30);
    // release bounce
    drive(0, 1, 30);
    drive(0, 0, 5);
    drive(0, 1, 3);
    drive(0, 0, 40);
    // bounce straddling the long-press point
    drive(0, 1, 60);
    drive(0, 0, 10);
    drive(0, 1, 20);
    drive(0, 0, 40);
    // mid-HELD reset with the button still down
    drive(0, 1, 30);
    drive(1, 1, 1);
    drive(0, 1, 30);
    drive(0, 0, 30);
    // boundary: exactly D+1 and D pad cycles
    drive(0, 1, D + 1);
    drive(0, 0, 30);
    drive(0, 1, D);
    drive(0, 0, 30);

    for (int i = 0; i < 200; i++) begin
      int len;
      if ($urandom_range(0, 29) == 0) begin
        drive(1, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(40, 120)
                                        : $urandom_range(1, 24);
      drive(0, 1'(i % 2), len);
    end
    drive(0, 0, 40);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
